// File: rtl/s_axi_regfile_pkg.sv
// Shared types for the AXI4 slave register file: response codes and the
// write/read channel state encodings.
package s_axi_regfile_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

endpackage

// File: rtl/axi_beat_ctr.sv
// Burst beat tracker: register index plus beat count for one AXI channel,
// with current and look-ahead last/index flags.
module axi_beat_ctr
  import s_axi_regfile_pkg::*;
#(
  parameter int IDX_W    = 30,
  parameter int NUM_REGS = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             load,
  input  logic             advance,
  input  logic [IDX_W-1:0] start_idx,
  input  logic [7:0]       len,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_next,
  output logic             last,
  output logic             last_next,
  output logic             oor
);

  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       cnt_reg;
  logic [7:0]       len_reg;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      idx_reg <= '0;
      cnt_reg <= '0;
      len_reg <= '0;
    end else if (load) begin
      idx_reg <= start_idx;
      cnt_reg <= '0;
      len_reg <= len;
    end else if (advance) begin
      idx_reg <= idx_reg + IDX_W'(1);
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign idx       = idx_reg;
  assign idx_next  = idx_reg + IDX_W'(1);
  assign last      = (cnt_reg == len_reg);
  // Read data is fetched one beat ahead, so it needs the next beat's flag.
  assign last_next = ((cnt_reg + 8'd1) == len_reg);
  assign oor       = (idx_reg >= IDX_W'(NUM_REGS));

endmodule

// File: rtl/s_axi_regfile.sv
// AXI4 slave register file with INCR bursts, byte strobes and OKAY/SLVERR.
// Optional read-only registers when S_AXI_REGFILE_RO_EN is defined.
module s_axi_regfile
  import s_axi_regfile_pkg::*;
#(
  parameter int                  DATA_W   = 32,
  parameter int                  ADDR_W   = 32,
  parameter int                  ID_W     = 4,
  parameter int                  NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [ID_W-1:0]            awid_i,
  input  logic [ADDR_W-1:0]          awaddr_i,
  input  logic [7:0]                 awlen_i,
  input  logic                       awvalid_i,
  output logic                       awready_o,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        wstrb_i,
  input  logic                       wlast_i,
  input  logic                       wvalid_i,
  output logic                       wready_o,
  output logic [ID_W-1:0]            bid_o,
  output logic [1:0]                 bresp_o,
  output logic                       bvalid_o,
  input  logic                       bready_i,
  input  logic [ID_W-1:0]            arid_i,
  input  logic [ADDR_W-1:0]          araddr_i,
  input  logic [7:0]                 arlen_i,
  input  logic                       arvalid_i,
  output logic                       arready_o,
  output logic [ID_W-1:0]            rid_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [1:0]                 rresp_o,
  output logic                       rlast_o,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;

`ifdef S_AXI_REGFILE_RO_EN
  localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK;
`else
  localparam logic [NUM_REGS-1:0] RO_EFF = '0;
`endif

  logic [NUM_REGS*DATA_W-1:0] regs_flat;

  // ---------------- write channel ----------------
  wstate_e          w_state_reg, w_state_next;
  logic             awready_reg, wready_reg, bvalid_reg, w_err_reg;
  logic [ID_W-1:0]  bid_reg;
  logic [IDX_W-1:0] w_idx, w_idx_next;
  logic             w_last, w_last_next, w_oor, w_ro;
  logic             aw_hs, w_hs, b_hs, wr_en;

  assign aw_hs = awvalid_i & awready_reg;
  assign w_hs  = wvalid_i & wready_reg;
  assign b_hs  = bvalid_reg & bready_i;

  axi_beat_ctr #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_wctr (
    .clk       (clk),
    .areset    (areset),
    .load      (aw_hs),
    .advance   (w_hs),
    .start_idx (awaddr_i[ADDR_W-1:ADDR_LSB]),
    .len       (awlen_i),
    .idx       (w_idx),
    .idx_next  (w_idx_next),
    .last      (w_last),
    .last_next (w_last_next),
    .oor       (w_oor)
  );

  always_comb begin
    w_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IDX_W'(i)) w_ro = RO_EFF[i];
    end
  end

  assign wr_en = w_hs & ~w_oor & ~w_ro;

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:  if (aw_hs) w_state_next = W_DATA;
      W_DATA:  if (w_hs && w_last) w_state_next = W_RESP;
      W_RESP:  if (b_hs) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      w_state_reg <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bid_reg     <= '0;
      w_err_reg   <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      awready_reg <= (w_state_next == W_IDLE);
      wready_reg  <= (w_state_next == W_DATA);
      bvalid_reg  <= (w_state_next == W_RESP);
      if (aw_hs) begin
        bid_reg   <= awid_i;
        w_err_reg <= 1'b0;
      end else if (w_hs && (w_oor || w_ro || (wlast_i != w_last))) begin
        w_err_reg <= 1'b1;
      end
    end
  end

  assign awready_o = awready_reg;
  assign wready_o  = wready_reg;
  assign bvalid_o  = bvalid_reg;
  assign bid_o     = bid_reg;
  assign bresp_o   = (bvalid_reg && w_err_reg) ? SLVERR : OKAY;

  // ---------------- register storage ----------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
        q_reg <= '0;
      end else if (wr_en && (w_idx == IDX_W'(gi))) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_i[b]) q_reg[8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end

    assign regs_flat[gi*DATA_W +: DATA_W] = q_reg;
  end

  assign regs_o = regs_flat;

  // ---------------- read channel ----------------
  rstate_e          r_state_reg, r_state_next;
  logic             arready_reg, rvalid_reg, rlast_reg;
  logic [ID_W-1:0]  rid_reg;
  logic [DATA_W-1:0] rdata_reg, rd_data;
  logic [1:0]       rresp_reg;
  logic [IDX_W-1:0] r_idx, r_idx_next, rd_idx;
  logic             r_last, r_last_next, r_oor, rd_last, rd_oor;
  logic             ar_hs, r_hs, r_adv;

  assign ar_hs = arvalid_i & arready_reg;
  assign r_hs  = rvalid_reg & rready_i;
  assign r_adv = r_hs & ~rlast_reg;

  axi_beat_ctr #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_rctr (
    .clk       (clk),
    .areset    (areset),
    .load      (ar_hs),
    .advance   (r_adv),
    .start_idx (araddr_i[ADDR_W-1:ADDR_LSB]),
    .len       (arlen_i),
    .idx       (r_idx),
    .idx_next  (r_idx_next),
    .last      (r_last),
    .last_next (r_last_next),
    .oor       (r_oor)
  );

  // The beat being loaded into the output register: first beat at AR, else the next one.
  assign rd_idx  = ar_hs ? araddr_i[ADDR_W-1:ADDR_LSB] : r_idx_next;
  assign rd_last = ar_hs ? (arlen_i == 8'd0) : r_last_next;
  assign rd_oor  = (rd_idx >= IDX_W'(NUM_REGS));

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i) && !RO_EFF[i]) rd_data = regs_flat[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (ar_hs) r_state_next = R_DATA;
      R_DATA:  if (r_hs && rlast_reg) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rid_reg     <= '0;
      rdata_reg   <= '0;
      rresp_reg   <= OKAY;
      rlast_reg   <= 1'b0;
    end else begin
      r_state_reg <= r_state_next;
      arready_reg <= (r_state_next == R_IDLE);
      rvalid_reg  <= (r_state_next == R_DATA);
      if (ar_hs) rid_reg <= arid_i;
      if (ar_hs || r_adv) begin
        rdata_reg <= rd_data;
        rresp_reg <= rd_oor ? SLVERR : OKAY;
        rlast_reg <= rd_last;
      end
    end
  end

  assign arready_o = arready_reg;
  assign rvalid_o  = rvalid_reg;
  assign rid_o     = rid_reg;
  assign rdata_o   = rdata_reg;
  assign rresp_o   = rresp_reg;
  assign rlast_o   = rlast_reg;

  logic unused_sink;
  assign unused_sink = ^{r_idx, r_last, r_oor, w_idx_next, w_last_next, awaddr_i, araddr_i};

endmodule

// File: tb/tb_s_axi_regfile.sv
// Directed testbench for s_axi_regfile; each task checks one scenario.
module tb_s_axi_regfile;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int ID_W     = 4;
  localparam int NUM_REGS = 8;

  logic                       clk = 1'b0;
  logic                       areset = 1'b0;
  logic [ID_W-1:0]            awid_i = '0;
  logic [ADDR_W-1:0]          awaddr_i = '0;
  logic [7:0]                 awlen_i = '0;
  logic                       awvalid_i = 1'b0;
  logic                       awready_o;
  logic [DATA_W-1:0]          wdata_i = '0;
  logic [DATA_W/8-1:0]        wstrb_i = '0;
  logic                       wlast_i = 1'b0;
  logic                       wvalid_i = 1'b0;
  logic                       wready_o;
  logic [ID_W-1:0]            bid_o;
  logic [1:0]                 bresp_o;
  logic                       bvalid_o;
  logic                       bready_i = 1'b0;
  logic [ID_W-1:0]            arid_i = '0;
  logic [ADDR_W-1:0]          araddr_i = '0;
  logic [7:0]                 arlen_i = '0;
  logic                       arvalid_i = 1'b0;
  logic                       arready_o;
  logic [ID_W-1:0]            rid_o;
  logic [DATA_W-1:0]          rdata_o;
  logic [1:0]                 rresp_o;
  logic                       rlast_o;
  logic                       rvalid_o;
  logic                       rready_i = 1'b0;
  logic [NUM_REGS*DATA_W-1:0] regs_o;

  always #5 clk = ~clk;

  s_axi_regfile #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .NUM_REGS(NUM_REGS), .RO_MASK(8'h01)
  ) dut (
    .clk(clk), .areset(areset),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o),
    .rready_i(rready_i), .regs_o(regs_o)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] wbuf [0:7];
  logic [3:0]  sbuf [0:7];
  logic [31:0] rbuf [0:7];
  logic [1:0]  rrbuf [0:7];
  logic        rlbuf [0:7];
  logic [3:0]  ridbuf [0:7];
  logic [31:0] exp_r0;

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input int early_last, output logic [1:0] resp, output logic [3:0] bid_got);
    int g;
    @(negedge clk);
    awid_i = id; awaddr_i = addr; awlen_i = 8'(len); awvalid_i = 1'b1;
    g = 0;
    while (!awready_o && g < 50) begin @(negedge clk); g++; end
    if (!awready_o) begin checks++; failures++; $display("FAIL aw_timeout got awready=0 need 1"); end
    @(posedge clk);
    @(negedge clk);
    awvalid_i = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wdata_i = wbuf[b]; wstrb_i = sbuf[b]; wvalid_i = 1'b1;
      wlast_i = (early_last >= 0) ? (b == early_last) : (b == len);
      g = 0;
      while (!wready_o && g < 50) begin @(negedge clk); g++; end
      if (!wready_o) begin checks++; failures++; $display("FAIL w_timeout beat %0d got wready=0 need 1", b); end
      @(posedge clk);
      @(negedge clk);
    end
    wvalid_i = 1'b0; wlast_i = 1'b0; bready_i = 1'b1;
    g = 0;
    while (!bvalid_o && g < 50) begin @(negedge clk); g++; end
    if (!bvalid_o) begin checks++; failures++; $display("FAIL b_timeout got bvalid=0 need 1"); end
    resp = bresp_o; bid_got = bid_o;
    @(posedge clk);
    @(negedge clk);
    bready_i = 1'b0;
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len, input bit toggle);
    int g, beats;
    bit stalled, ph;
    logic [31:0] held;
    @(negedge clk);
    arid_i = id; araddr_i = addr; arlen_i = 8'(len); arvalid_i = 1'b1;
    g = 0;
    while (!arready_o && g < 50) begin @(negedge clk); g++; end
    if (!arready_o) begin checks++; failures++; $display("FAIL ar_timeout got arready=0 need 1"); end
    @(posedge clk);
    @(negedge clk);
    arvalid_i = 1'b0;
    beats = 0; g = 0; stalled = 0; ph = 0; held = '0;
    while (beats <= len && g < 100) begin
      if (stalled) begin
        checks++;
        if (rdata_o !== held) begin
          failures++; $display("FAIL stall_stable got %h need %h", rdata_o, held);
        end
      end
      rready_i = toggle ? ph : 1'b1;
      ph = ~ph;
      stalled = 0;
      if (rvalid_o && rready_i) begin
        rbuf[beats] = rdata_o; rrbuf[beats] = rresp_o; rlbuf[beats] = rlast_o; ridbuf[beats] = rid_o;
        beats++;
      end else if (rvalid_o) begin
        stalled = 1; held = rdata_o;
      end
      @(posedge clk);
      @(negedge clk);
      g++;
    end
    rready_i = 1'b0;
    if (beats <= len) begin checks++; failures++; $display("FAIL r_timeout got %0d beats need %0d", beats, len + 1); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({awready_o, wready_o, bvalid_o, arready_o, rvalid_o} !== 5'b0) begin
      failures++; $display("FAIL reset_handshakes got %b need 00000", {awready_o, wready_o, bvalid_o, arready_o, rvalid_o});
    end
    checks++;
    if (regs_o !== '0) begin failures++; $display("FAIL reset_regs got %h need 0", regs_o); end
    areset = 1'b1;
    #1;
    checks++;
    if (awready_o !== 1'b0) begin failures++; $display("FAIL awready_pre_edge got %b need 0", awready_o); end
    @(negedge clk);
    checks++;
    if ({awready_o, arready_o} !== 2'b11) begin
      failures++; $display("FAIL ready_after_release got %b need 11", {awready_o, arready_o});
    end
  endtask

  task automatic test_single_write();
    logic [1:0] resp; logic [3:0] bid_got;
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'b0101;
    write_burst(4'h3, 32'h4, 0, -1, resp, bid_got);
    $display("single_write reg1=%h bresp=%0d bid=%0d", regs_o[63:32], resp, bid_got);
    checks++;
    if (regs_o[63:32] !== 32'h00AD00EF) begin failures++; $display("FAIL single_write_data got %h need 00ad00ef", regs_o[63:32]); end
    checks++;
    if (resp !== 2'b00) begin failures++; $display("FAIL single_write_resp got %b need 00", resp); end
    checks++;
    if (bid_got !== 4'h3) begin failures++; $display("FAIL single_write_bid got %h need 3", bid_got); end
  endtask

  task automatic test_read_only();
    logic [1:0] resp, exp_resp; logic [3:0] bid_got;
`ifdef S_AXI_REGFILE_RO_EN
    exp_resp = 2'b10; exp_r0 = 32'h0;
`else
    exp_resp = 2'b00; exp_r0 = 32'h55;
`endif
    wbuf[0] = 32'h55; sbuf[0] = 4'hF;
    write_burst(4'h1, 32'h0, 0, -1, resp, bid_got);
    read_burst(4'h2, 32'h0, 0, 1'b0);
    $display("read_only bresp=%0d reg0=%h rdata=%h", resp, regs_o[31:0], rbuf[0]);
    checks++;
    if (resp !== exp_resp) begin failures++; $display("FAIL ro_resp got %b need %b", resp, exp_resp); end
    checks++;
    if (regs_o[31:0] !== exp_r0) begin failures++; $display("FAIL ro_reg got %h need %h", regs_o[31:0], exp_r0); end
    checks++;
    if (rbuf[0] !== exp_r0 || rrbuf[0] !== 2'b00) begin
      failures++; $display("FAIL ro_read got %h/%b need %h/00", rbuf[0], rrbuf[0], exp_r0);
    end
  endtask

  task automatic test_incr_oor();
    logic [1:0] resp; logic [3:0] bid_got;
    wbuf[0] = 32'h66666666; wbuf[1] = 32'h77777777; wbuf[2] = 32'h88888888; wbuf[3] = 32'h99999999;
    for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
    write_burst(4'hA, 32'h18, 3, -1, resp, bid_got);
    $display("incr_oor bresp=%0d reg6=%h reg7=%h", resp, regs_o[6*32 +: 32], regs_o[7*32 +: 32]);
    checks++;
    if (resp !== 2'b10 || bid_got !== 4'hA) begin failures++; $display("FAIL incr_oor_resp got %b/%h need 10/a", resp, bid_got); end
    checks++;
    if (regs_o[6*32 +: 32] !== 32'h66666666) begin failures++; $display("FAIL incr_reg6 got %h need 66666666", regs_o[6*32 +: 32]); end
    checks++;
    if (regs_o[7*32 +: 32] !== 32'h77777777) begin failures++; $display("FAIL incr_reg7 got %h need 77777777", regs_o[7*32 +: 32]); end
    checks++;
    if (regs_o[63:32] !== 32'h00AD00EF) begin failures++; $display("FAIL incr_reg1_kept got %h need 00ad00ef", regs_o[63:32]); end
  endtask

  task automatic test_same_edge();
    logic [1:0] resp; logic [3:0] bid_got;
    int g;
    wbuf[0] = 32'h11; sbuf[0] = 4'hF;
    write_burst(4'h0, 32'h8, 0, -1, resp, bid_got);
    @(negedge clk);
    awid_i = 4'h1; awaddr_i = 32'h8; awlen_i = 8'd0; awvalid_i = 1'b1;
    g = 0;
    while (!awready_o && g < 50) begin @(negedge clk); g++; end
    @(posedge clk);
    @(negedge clk);
    awvalid_i = 1'b0;
    checks++;
    if ({wready_o, arready_o} !== 2'b11) begin failures++; $display("FAIL same_edge_ready got %b need 11", {wready_o, arready_o}); end
    wdata_i = 32'h22; wstrb_i = 4'hF; wlast_i = 1'b1; wvalid_i = 1'b1;
    arid_i = 4'h6; araddr_i = 32'h8; arlen_i = 8'd0; arvalid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wvalid_i = 1'b0; wlast_i = 1'b0; arvalid_i = 1'b0;
    $display("same_edge rdata=%h reg2=%h bresp=%0d", rdata_o, regs_o[2*32 +: 32], bresp_o);
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'h11) begin failures++; $display("FAIL same_edge_old got %b/%h need 1/00000011", rvalid_o, rdata_o); end
    checks++;
    if (regs_o[2*32 +: 32] !== 32'h22) begin failures++; $display("FAIL same_edge_new got %h need 00000022", regs_o[2*32 +: 32]); end
    checks++;
    if (bvalid_o !== 1'b1 || bresp_o !== 2'b00) begin failures++; $display("FAIL same_edge_b got %b/%b need 1/00", bvalid_o, bresp_o); end
    rready_i = 1'b1; bready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready_i = 1'b0; bready_i = 1'b0;
    read_burst(4'h6, 32'h8, 0, 1'b0);
    checks++;
    if (rbuf[0] !== 32'h22) begin failures++; $display("FAIL same_edge_later got %h need 00000022", rbuf[0]); end
  endtask

  task automatic test_read_stall();
    logic [31:0] exp_d [0:2];
    exp_d[0] = exp_r0; exp_d[1] = 32'h00AD00EF; exp_d[2] = 32'h22;
    read_burst(4'h5, 32'h0, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      $display("read_stall beat %0d rdata=%h rresp=%0d rlast=%0d rid=%0d", i, rbuf[i], rrbuf[i], rlbuf[i], ridbuf[i]);
      checks++;
      if (rbuf[i] !== exp_d[i] || rrbuf[i] !== 2'b00) begin
        failures++; $display("FAIL stall_beat%0d got %h/%b need %h/00", i, rbuf[i], rrbuf[i], exp_d[i]);
      end
      checks++;
      if (rlbuf[i] !== (i == 2) || ridbuf[i] !== 4'h5) begin
        failures++; $display("FAIL stall_last%0d got %b/%h need %b/5", i, rlbuf[i], ridbuf[i], (i == 2));
      end
    end
  endtask

  task automatic test_wlast_early();
    logic [1:0] resp; logic [3:0] bid_got;
    wbuf[0] = 32'hAAAA0004; wbuf[1] = 32'hBBBB0005; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    write_burst(4'h7, 32'h10, 1, 0, resp, bid_got);
    $display("wlast_early bresp=%0d reg4=%h reg5=%h", resp, regs_o[4*32 +: 32], regs_o[5*32 +: 32]);
    checks++;
    if (resp !== 2'b10) begin failures++; $display("FAIL wlast_resp got %b need 10", resp); end
    checks++;
    if (regs_o[4*32 +: 64] !== 64'hBBBB0005_AAAA0004) begin
      failures++; $display("FAIL wlast_regs got %h need bbbb0005aaaa0004", regs_o[4*32 +: 64]);
    end
  endtask

  task automatic test_read_oor();
    read_burst(4'h9, 32'h1C, 1, 1'b0);
    $display("read_oor beat0=%h/%0d/%0d beat1=%h/%0d/%0d", rbuf[0], rrbuf[0], rlbuf[0], rbuf[1], rrbuf[1], rlbuf[1]);
    checks++;
    if (rbuf[0] !== 32'h77777777 || rrbuf[0] !== 2'b00 || rlbuf[0] !== 1'b0) begin
      failures++; $display("FAIL oor_beat0 got %h/%b/%b need 77777777/00/0", rbuf[0], rrbuf[0], rlbuf[0]);
    end
    checks++;
    if (rbuf[1] !== 32'h0 || rrbuf[1] !== 2'b10 || rlbuf[1] !== 1'b1) begin
      failures++; $display("FAIL oor_beat1 got %h/%b/%b need 00000000/10/1", rbuf[1], rrbuf[1], rlbuf[1]);
    end
  endtask

  task automatic test_mid_reset();
    int g;
    @(negedge clk);
    awid_i = 4'h2; awaddr_i = 32'h0; awlen_i = 8'd3; awvalid_i = 1'b1;
    g = 0;
    while (!awready_o && g < 50) begin @(negedge clk); g++; end
    @(posedge clk);
    @(negedge clk);
    awvalid_i = 1'b0;
    wdata_i = 32'h12345678; wstrb_i = 4'hF; wlast_i = 1'b0; wvalid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    #1;
    $display("mid_reset wready=%0d bvalid=%0d regs=%h", wready_o, bvalid_o, regs_o);
    checks++;
    if ({wready_o, bvalid_o, awready_o} !== 3'b000) begin
      failures++; $display("FAIL mid_reset_outs got %b need 000", {wready_o, bvalid_o, awready_o});
    end
    checks++;
    if (regs_o !== '0) begin failures++; $display("FAIL mid_reset_regs got %h need 0", regs_o); end
    wvalid_i = 1'b0;
    @(negedge clk);
    areset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({awready_o, wready_o, bvalid_o} !== 3'b100) begin
      failures++; $display("FAIL mid_reset_idle got %b need 100", {awready_o, wready_o, bvalid_o});
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_only();
    test_incr_oor();
    test_same_edge();
    test_read_stall();
    test_wlast_early();
    test_read_oor();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running need finished");
    $fatal(1, "timeout");
  end

endmodule
